// File: rtl/successive_approximation_search.sv
// ---------------------------------------------------------------------------
// successive_approximation_search
//
// Binary-search engine for a target value that only an external comparator
// can see. The block issues WORD_WIDTH trial values, MSB first. Each
// comparator answer (target >= trial) keeps or drops the trial bit, and the
// converged value is then presented as the result. In signed mode the search
// runs on an offset-binary accumulator: the MSB is flipped on the way out,
// so the same unsigned bisection also covers 2's-complement targets.
//
// Ports
//   clock          rising-edge clock for all state
//   clear          synchronous, active-high reset; aborts any search
//   start_valid    request to begin a new search       (handshake with start_ready)
//   start_ready    high in IDLE
//   trial_value    candidate value sent to the comparator
//   trial_valid    high in ISSUE                        (handshake with trial_ready)
//   trial_ready    comparator accepts the trial
//   compare_valid  comparator response present          (handshake with compare_ready)
//   compare_gte    response bit: target >= trial_value
//   compare_ready  high in WAIT
//   result_value   converged search result
//   result_valid   high in DONE                         (handshake with result_ready)
//   result_ready   consumer accepts the result
//
// All outputs are decoded from registers only. No input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module successive_approximation_search #(
    parameter int WORD_WIDTH = 0,    // instantiate with 1 or more
    parameter bit SIGNED     = 1'b0  // 0: unsigned search, 1: 2's-complement search
) (
    input  logic                                          clock,
    input  logic                                          clear,
    input  logic                                          start_valid,
    output logic                                          start_ready,
    output logic [((WORD_WIDTH > 0) ? WORD_WIDTH : 1)-1:0] trial_value,
    output logic                                          trial_valid,
    input  logic                                          trial_ready,
    input  logic                                          compare_valid,
    input  logic                                          compare_gte,
    output logic                                          compare_ready,
    output logic [((WORD_WIDTH > 0) ? WORD_WIDTH : 1)-1:0] result_value,
    output logic                                          result_valid,
    input  logic                                          result_ready
);

    // A WORD_WIDTH of 0 is not a usable width. Clamping the width to at least
    // 1 keeps every vector range legal when the default is elaborated.
    localparam int W     = (WORD_WIDTH > 0) ? WORD_WIDTH : 1;
    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [W-1:0]     ONE      = W'(1);
    // In signed mode, flipping the MSB maps 2's complement onto offset binary,
    // which preserves ordering, so the accumulator is always bisected unsigned.
    localparam logic [W-1:0]     MSB_MASK = SIGNED ? (ONE << (W - 1)) : '0;
    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     u_q, u_d;        // offset-binary accumulator
    logic [IDX_W-1:0] idx_q, idx_d;    // bit currently under test
    logic [W-1:0]     trial_u;         // candidate in accumulator space
    logic             searching;

    assign trial_u   = u_q | (ONE << idx_q);
    assign searching = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    // U changes only on the response handshake, so the trial stays frozen from
    // ISSUE entry until its answer is taken. Outside a search only U is shown,
    // so an unsigned block reads zero after clear.
    assign trial_value  = (searching ? trial_u : u_q) ^ MSB_MASK;
    assign result_value = u_q ^ MSB_MASK;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise the tool would infer a latch.
        state_d       = state_q;
        u_d           = u_q;
        idx_d         = idx_q;
        start_ready   = 1'b0;
        trial_valid   = 1'b0;
        compare_ready = 1'b0;
        result_valid  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    u_d     = '0;
                    idx_d   = TOP_IDX;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                trial_valid = 1'b1;
                if (trial_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                compare_ready = 1'b1;
                if (compare_valid) begin
                    if (compare_gte) begin
                        u_d = trial_u;
                    end
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                result_valid = 1'b1;
                // Returning to IDLE here means a start cannot coincide with
                // the result handshake. The earliest start is one cycle later.
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // clear has priority over any handshake in the same cycle. It discards an
    // in-flight search without ever presenting a partial result.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
            u_q     <= '0;
            idx_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so that every
            // flop samples the values from before this edge.
            state_q <= state_d;
            u_q     <= u_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_successive_approximation_search.sv
// ---------------------------------------------------------------------------
// Bench for successive_approximation_search. The bench instantiates two units,
// one 8-bit unsigned and one 4-bit signed. A stimulus thread pushes the
// expected trials, results and targets into queues. A negedge monitor pops and
// compares these whenever a DUT handshake is about to complete. The monitor
// also checks latency, hold-while-stalled and the state-exclusive outputs.
// ---------------------------------------------------------------------------
module tb_successive_approximation_search;

    logic clk = 1'b0;
    logic clear = 1'b1;
    logic start_valid_a = 1'b0, start_valid_b = 1'b0;
    logic trial_ready = 1'b0, compare_valid = 1'b0, result_ready = 1'b0;

    logic       start_ready_a, trial_valid_a, compare_ready_a, result_valid_a;
    logic [7:0] trial_value_a, result_value_a;
    logic       start_ready_b, trial_valid_b, compare_ready_b, result_valid_b;
    logic [3:0] trial_value_b, result_value_b;

    // Comparator model: it holds the target of the running search.
    logic [7:0] cur_tgt_a = '0;
    logic [3:0] cur_tgt_b = '0;
    logic       gte_a, gte_b;
    assign gte_a = (cur_tgt_a >= trial_value_a);
    assign gte_b = ($signed(cur_tgt_b) >= $signed(trial_value_b));

    successive_approximation_search #(.WORD_WIDTH(8), .SIGNED(1'b0)) dut_a (
        .clock(clk), .clear(clear),
        .start_valid(start_valid_a), .start_ready(start_ready_a),
        .trial_value(trial_value_a), .trial_valid(trial_valid_a), .trial_ready(trial_ready),
        .compare_valid(compare_valid), .compare_gte(gte_a), .compare_ready(compare_ready_a),
        .result_value(result_value_a), .result_valid(result_valid_a), .result_ready(result_ready)
    );

    successive_approximation_search #(.WORD_WIDTH(4), .SIGNED(1'b1)) dut_b (
        .clock(clk), .clear(clear),
        .start_valid(start_valid_b), .start_ready(start_ready_b),
        .trial_value(trial_value_b), .trial_valid(trial_valid_b), .trial_ready(trial_ready),
        .compare_valid(compare_valid), .compare_gte(gte_b), .compare_ready(compare_ready_b),
        .result_value(result_value_b), .result_valid(result_valid_b), .result_ready(result_ready)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit sel      = 1'b0;   // 0: unit A (8u), 1: unit B (4s)
    bit stall_en = 1'b0;
    bit b2b      = 1'b0;

    int exp_trial[$];
    int exp_result[$];
    int tgt_q[$];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // View of whichever unit is under test.
    logic       v_start_ready, v_start_valid, v_trial_valid, v_compare_ready, v_result_valid;
    logic [7:0] v_trial, v_result;
    always_comb begin
        v_start_ready   = sel ? start_ready_b   : start_ready_a;
        v_start_valid   = sel ? start_valid_b   : start_valid_a;
        v_trial_valid   = sel ? trial_valid_b   : trial_valid_a;
        v_compare_ready = sel ? compare_ready_b : compare_ready_a;
        v_result_valid  = sel ? result_valid_b  : result_valid_a;
        v_trial         = sel ? {4'b0, trial_value_b}  : trial_value_a;
        v_result        = sel ? {4'b0, result_value_b} : result_value_a;
    end

    // ---------------- partner driver ----------------
    initial forever begin
        @(posedge clk);
        #1;
        trial_ready   = stall_en ? ($urandom_range(0, 99) < 60) : 1'b1;
        compare_valid = stall_en ? ($urandom_range(0, 99) < 60) : 1'b1;
        result_ready  = stall_en ? ($urandom_range(0, 99) < 60) : 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    int   starts_seen = 0;
    int   start_edge = 0, stalls = 0, trials_this = 0;
    int   last_result_edge = 0;
    bit   have_last_result = 1'b0;
    bit   prev_trial_stall = 1'b0, prev_result_stall = 1'b0;
    logic [7:0] prev_trial = '0, prev_result = '0, accepted_trial = '0;

    always @(negedge clk) begin
        int w;
        int onehot;
        w = sel ? 4 : 8;
        if (clear) begin
            stalls            = 0;
            trials_this       = 0;
            prev_trial_stall  = 1'b0;
            prev_result_stall = 1'b0;
            have_last_result  = 1'b0;
        end else begin
            onehot = int'(v_start_ready) + int'(v_trial_valid) + int'(v_compare_ready) + int'(v_result_valid);
            check("one_state_output", onehot, 1);

            if (prev_trial_stall) begin
                check("trial_hold_valid", int'(v_trial_valid), 1);
                check("trial_hold_value", int'(v_trial), int'(prev_trial));
            end
            if (prev_result_stall) begin
                check("result_hold_valid", int'(v_result_valid), 1);
                check("result_hold_value", int'(v_result), int'(prev_result));
            end

            if (v_start_ready && v_start_valid) begin
                if (b2b && have_last_result)
                    check("b2b_start_edge", cyc + 1, last_result_edge + 1);
                start_edge  = cyc + 1;
                stalls      = 0;
                trials_this = 0;
                starts_seen++;
                if (tgt_q.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else if (sel) begin
                    cur_tgt_b = 4'(tgt_q.pop_front());
                end else begin
                    cur_tgt_a = 8'(tgt_q.pop_front());
                end
            end

            if (v_trial_valid) begin
                if (trial_ready) begin
                    trials_this++;
                    accepted_trial = v_trial;
                    if (exp_trial.size() == 0) check("unexpected_trial", int'(v_trial), -1);
                    else check("trial_value", int'(v_trial), exp_trial.pop_front());
                end else begin
                    stalls++;
                end
            end

            if (v_compare_ready) begin
                check("trial_stable_in_wait", int'(v_trial), int'(accepted_trial));
                if (!compare_valid) stalls++;
            end

            if (v_result_valid) begin
                if (result_ready) begin
                    if (exp_result.size() == 0) check("unexpected_result", int'(v_result), -1);
                    else check("result_value", int'(v_result), exp_result.pop_front());
                    check("trial_count", trials_this, w);
                    check("latency", cyc + 1 - start_edge, 2 * w + 1 + stalls);
                    last_result_edge = cyc + 1;
                    have_last_result = 1'b1;
                end else begin
                    stalls++;
                end
            end

            prev_trial_stall  = v_trial_valid && !trial_ready;
            prev_trial        = v_trial;
            prev_result_stall = v_result_valid && !result_ready;
            prev_result       = v_result;
        end
    end

    // ---------------- reference model ----------------
    // A plain bisection over the ordered value range. Signed targets are first
    // moved into 0..2^w-1 by adding 2^(w-1).
    function automatic void push_model(input int target);
        int w, offset, mask, ot, acc, trial;
        w      = sel ? 4 : 8;
        offset = sel ? (1 << (w - 1)) : 0;
        mask   = (1 << w) - 1;
        ot     = (target + offset) & mask;
        acc    = 0;
        for (int b = w - 1; b >= 0; b--) begin
            trial = acc + (1 << b);
            exp_trial.push_back((trial - offset) & mask);
            if (ot >= trial) acc = trial;
        end
        exp_result.push_back(target & mask);
        tgt_q.push_back(target & mask);
    endfunction

    function automatic void push_list(input int n, input int lst[8], input int target);
        for (int i = 0; i < n; i++) exp_trial.push_back(lst[i]);
        exp_result.push_back(target);
        tgt_q.push_back(target);
    endfunction

    function automatic void flush();
        exp_trial.delete();
        exp_result.delete();
        tgt_q.delete();
    endfunction

    task automatic run_starts(input int n_starts, input int budget);
        int base, cnt;
        base = starts_seen;
        cnt  = 0;
        @(posedge clk);
        #1;
        start_valid_a = !sel;
        start_valid_b = sel;
        while (starts_seen < base + n_starts && cnt < budget) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        start_valid_a = 1'b0;
        start_valid_b = 1'b0;
        while (exp_result.size() != 0 && cnt < budget) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("search_completed", exp_result.size(), 0);
        if (exp_result.size() != 0) begin
            flush();
            clear = 1'b1;
            @(posedge clk);
            #1;
            clear = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waits;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("rst_start_ready", int'(start_ready_a), 1);
        check("rst_trial_valid", int'(trial_valid_a), 0);
        check("rst_compare_ready", int'(compare_ready_a), 0);
        check("rst_result_valid", int'(result_valid_a), 0);
        check("rst_trial_value", int'(trial_value_a), 0);
        check("rst_result_value", int'(result_value_a), 0);
        check("rst_start_ready_b", int'(start_ready_b), 1);

        // Unsigned 8-bit directed searches.
        sel = 1'b0;
        stall_en = 1'b0;
        push_list(8, '{'h80, 'hC0, 'hA0, 'hB0, 'hA8, 'hA4, 'hA6, 'hA5}, 'hA5);
        run_starts(1, 200);
        push_list(8, '{'h80, 'hC0, 'hE0, 'hF0, 'hF8, 'hFC, 'hFE, 'hFF}, 'hFF);
        run_starts(1, 200);
        push_list(8, '{'h80, 'h40, 'h20, 'h10, 'h08, 'h04, 'h02, 'h01}, 'h00);
        run_starts(1, 200);
        for (int i = 0; i < 5; i++) begin
            push_model(int'($urandom_range(0, 255)));
            run_starts(1, 200);
        end

        // Random stalls on every partner handshake.
        stall_en = 1'b1;
        push_list(8, '{'h80, 'hC0, 'hA0, 'hB0, 'hA8, 'hA4, 'hA6, 'hA5}, 'hA5);
        run_starts(1, 600);
        for (int i = 0; i < 10; i++) begin
            push_model(int'($urandom_range(0, 255)));
            run_starts(1, 600);
        end

        // Back-to-back searches with start_valid held through DONE.
        stall_en = 1'b0;
        @(posedge clk);
        #1;
        have_last_result = 1'b0;
        b2b = 1'b1;
        push_model('h3C);
        push_model('hC3);
        run_starts(2, 300);
        b2b = 1'b0;

        // Clear during the third WAIT.
        push_model('h5A);
        @(posedge clk);
        #1;
        start_valid_a = 1'b1;
        waits = 0;
        for (int c = 0; c < 100 && waits < 3; c++) begin
            @(posedge clk);
            #1;
            start_valid_a = 1'b0;
            if (compare_ready_a) waits++;
        end
        check("reached_third_wait", waits, 3);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        flush();
        @(negedge clk);
        check("clr_trial_valid", int'(trial_valid_a), 0);
        check("clr_compare_ready", int'(compare_ready_a), 0);
        check("clr_result_valid", int'(result_valid_a), 0);
        check("clr_start_ready", int'(start_ready_a), 1);
        check("clr_trial_value", int'(trial_value_a), 0);
        check("clr_result_value", int'(result_value_a), 0);
        push_model('h5A);
        run_starts(1, 200);

        // Signed 4-bit searches.
        sel = 1'b1;
        push_list(4, '{'h0, 'hC, 'hE, 'hD, 0, 0, 0, 0}, 'hD);
        run_starts(1, 200);
        push_model(-8);
        run_starts(1, 200);
        push_model(7);
        run_starts(1, 200);
        stall_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_model(int'($urandom_range(0, 15)) - 8);
            run_starts(1, 400);
        end
        stall_en = 1'b0;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
